// File: rtl/cla_carry_pipe.sv
// rtl/cla_carry_pipe.sv - pipelined CLA carry generator with per-carry fault injection; CLA_CARRY_CHK_EN adds a shadow check chain
module cla_carry_pipe #(
  parameter int WIDTH      = 16,
  parameter int NG         = 128,
  parameter int GID_BASE   = 0,
  parameter int FAULT_PROP = 0,
  parameter int FAULT_FLIP = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             C0,
  input  logic [WIDTH-1:0] P,
  input  logic [WIDTH-1:0] G,
  input  logic [NG-1:0]    fault_en_bus,
  input  logic             fault_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C
`ifdef CLA_CARRY_CHK_EN
  ,
  output logic             chk_err,
  output logic             chk_sticky
`endif
);

  localparam int NS = WIDTH / 4;

  logic                     adv;
  logic [NS-1:0]            v_q, v_d, co_q, co_d, ci_s;
  logic [NS-1:0][WIDTH-1:0] c_q, c_d, c_s, p_q, p_d, g_q, g_d;

  function automatic logic fault_mux(input logic raw, input logic en, input logic fv);
    if (!en) return raw;
    return (FAULT_FLIP != 0) ? (raw ^ fv) : fv;
  endfunction

  assign adv       = !v_q[NS-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[NS-1];
  assign C         = c_q[NS-1];

  // Stage 0 is fed straight from the ports; stage s>0 from the registers of stage s-1.
  always_comb begin
    v_d[0]  = in_valid;
    ci_s[0] = C0;
    c_s[0]  = '0;
    p_d[0]  = P;
    g_d[0]  = G;
    for (int s = 1; s < NS; s++) begin
      v_d[s]  = v_q[s-1];
      ci_s[s] = co_q[s-1];
      c_s[s]  = c_q[s-1];
      p_d[s]  = p_q[s-1];
      g_d[s]  = g_q[s-1];
    end
  end

  always_comb begin
    logic ch, raw, flt;
    int   b;
    c_d  = c_s;
    co_d = '0;
    ch   = 1'b0;
    raw  = 1'b0;
    flt  = 1'b0;
    b    = 0;
    for (int s = 0; s < NS; s++) begin
      ch = ci_s[s];
      for (int k = 0; k < 4; k++) begin
        b          = 4 * s + k;
        raw        = g_d[s][b] | (p_d[s][b] & ch);
        flt        = fault_mux(raw, fault_en_bus[GID_BASE + b], fault_val);
        c_d[s][b]  = flt;
        ch         = (FAULT_PROP != 0) ? flt : raw;
      end
      co_d[s] = ch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q  <= '0;
      c_q  <= '0;
      co_q <= '0;
      p_q  <= '0;
      g_q  <= '0;
    end else if (adv) begin
      v_q  <= v_d;
      c_q  <= c_d;
      co_q <= co_d;
      p_q  <= p_d;
      g_q  <= g_d;
    end
  end

`ifdef CLA_CARRY_CHK_EN
  // Fault-free reference carries travelling in lockstep with the main pipe.
  logic [NS-1:0]            sco_q, sco_d, sci_s;
  logic [NS-1:0][WIDTH-1:0] sh_q, sh_d, sh_s;
  logic                     sticky_q;

  always_comb begin
    sci_s[0] = C0;
    sh_s[0]  = '0;
    for (int s = 1; s < NS; s++) begin
      sci_s[s] = sco_q[s-1];
      sh_s[s]  = sh_q[s-1];
    end
  end

  always_comb begin
    logic sch;
    int   sb;
    sh_d  = sh_s;
    sco_d = '0;
    sch   = 1'b0;
    sb    = 0;
    for (int s = 0; s < NS; s++) begin
      sch = sci_s[s];
      for (int k = 0; k < 4; k++) begin
        sb         = 4 * s + k;
        sch        = g_d[s][sb] | (p_d[s][sb] & sch);
        sh_d[s][sb] = sch;
      end
      sco_d[s] = sch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q     <= '0;
      sco_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      if (adv) begin
        sh_q  <= sh_d;
        sco_q <= sco_d;
      end
      if (chk_err && out_ready) sticky_q <= 1'b1;
    end
  end

  assign chk_err    = v_q[NS-1] && (c_q[NS-1] != sh_q[NS-1]);
  assign chk_sticky = sticky_q;
`endif

endmodule
